// File: rtl/screen_sequencer.sv
// Game-screen sequencer for the VGA layer compositor.
// Walks TITLE -> PLAY -> (FLASH) -> OVER, tracks score and lives, and drives
// the per-layer enables and message select. All outputs are registered.
// Optional feature: define SCREEN_SEQ_MSG_BLINK_EN to blink the message layer
// on the TITLE screen (toggles every BLINK_FRAMES frame ticks).
module screen_sequencer #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned WIN_SCORE    = 10,
  parameter int unsigned FLASH_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 8,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       coin_hit,
  input  logic       char_hit,
  output logic [1:0] state,
  output logic       char_en,
  output logic       coin_en,
  output logic       mess_en,
  output logic [1:0] msg_sel,
  output logic [7:0] score,
  output logic [1:0] lives
);

  typedef enum logic [1:0] {
    S_TITLE = 2'd0,
    S_PLAY  = 2'd1,
    S_FLASH = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  localparam logic [1:0] MSG_TITLE = 2'd0;
  localparam logic [1:0] MSG_WIN   = 2'd1;
  localparam logic [1:0] MSG_LOSE  = 2'd2;

  localparam logic [1:0] LIVES_C = 2'(LIVES_INIT);
  localparam logic [7:0] WIN_C   = 8'(WIN_SCORE);
  localparam logic [7:0] FLASH_C = 8'(FLASH_FRAMES);
  localparam logic [7:0] BLINK_C = 8'(BLINK_FRAMES);
  localparam logic [7:0] OVER_C  = 8'(OVER_FRAMES);

  state_e     state_q;
  logic       start_q;
  logic [7:0] frame_cnt_q;
  logic [7:0] blink_cnt_q;
  logic       char_en_q;
  logic       coin_en_q;
  logic       mess_en_q;
  logic [1:0] msg_sel_q;
  logic [7:0] score_q;
  logic [1:0] lives_q;

  // Next-value helpers shared by several state branches.
  logic       start_rise_d;
  logic [7:0] score_d;
  logic [1:0] lives_d;
  logic [7:0] frame_cnt_d;
  logic [7:0] blink_cnt_d;
  logic       coin_win_d;

  assign start_rise_d = start_btn & ~start_q;
  assign score_d      = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
  assign lives_d      = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
  assign frame_cnt_d  = frame_cnt_q + 8'd1;
  assign blink_cnt_d  = blink_cnt_q + 8'd1;
  assign coin_win_d   = coin_hit & (score_d == WIN_C);

  // Screen FSM: state, counters and all registered outputs.
  // NOTE: sequential state is assigned with <= so every branch reads the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_TITLE;
      start_q     <= 1'b1;  // a button held through reset must not start a game
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
      char_en_q   <= 1'b0;
      coin_en_q   <= 1'b0;
      mess_en_q   <= 1'b1;
      msg_sel_q   <= MSG_TITLE;
      score_q     <= 8'd0;
      lives_q     <= 2'd0;
    end else begin
      start_q <= start_btn;
      case (state_q)
        S_TITLE: begin
          if (start_rise_d) begin
            state_q     <= S_PLAY;
            score_q     <= 8'd0;
            lives_q     <= LIVES_C;
            char_en_q   <= 1'b1;
            coin_en_q   <= 1'b1;
            mess_en_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
          end
`ifdef SCREEN_SEQ_MSG_BLINK_EN
          else if (frame_tick) begin
            if (frame_cnt_d == BLINK_C) begin
              frame_cnt_q <= 8'd0;
              mess_en_q   <= ~mess_en_q;
            end else begin
              frame_cnt_q <= frame_cnt_d;
            end
          end
`endif
        end

        S_PLAY: begin
          if (coin_hit) score_q <= score_d;
          if (char_hit) lives_q <= lives_d;
          // Win beats lose, lose beats a plain hit.
          if (coin_win_d) begin
            state_q     <= S_OVER;
            msg_sel_q   <= MSG_WIN;
            char_en_q   <= 1'b0;
            coin_en_q   <= 1'b0;
            mess_en_q   <= 1'b1;
            frame_cnt_q <= 8'd0;
          end else if (char_hit && lives_d == 2'd0) begin
            state_q     <= S_OVER;
            msg_sel_q   <= MSG_LOSE;
            char_en_q   <= 1'b0;
            coin_en_q   <= 1'b0;
            mess_en_q   <= 1'b1;
            frame_cnt_q <= 8'd0;
          end else if (char_hit) begin
            state_q     <= S_FLASH;
            char_en_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            blink_cnt_q <= 8'd0;
          end
        end

        S_FLASH: begin
          // Invulnerable: char_hit is ignored, coins still count.
          if (coin_hit) score_q <= score_d;
          if (coin_win_d) begin
            state_q     <= S_OVER;
            msg_sel_q   <= MSG_WIN;
            char_en_q   <= 1'b0;
            coin_en_q   <= 1'b0;
            mess_en_q   <= 1'b1;
            frame_cnt_q <= 8'd0;
          end else if (frame_tick) begin
            if (frame_cnt_d == FLASH_C) begin
              state_q     <= S_PLAY;
              char_en_q   <= 1'b1;
              frame_cnt_q <= 8'd0;
              blink_cnt_q <= 8'd0;
            end else begin
              frame_cnt_q <= frame_cnt_d;
              if (blink_cnt_d == BLINK_C) begin
                blink_cnt_q <= 8'd0;
                char_en_q   <= ~char_en_q;
              end else begin
                blink_cnt_q <= blink_cnt_d;
              end
            end
          end
        end

        S_OVER: begin
          if (start_rise_d || (frame_tick && frame_cnt_d == OVER_C)) begin
            state_q     <= S_TITLE;
            msg_sel_q   <= MSG_TITLE;
            mess_en_q   <= 1'b1;
            frame_cnt_q <= 8'd0;
          end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_d;
          end
        end

        default: begin
          state_q     <= S_TITLE;
          frame_cnt_q <= 8'd0;
          blink_cnt_q <= 8'd0;
          char_en_q   <= 1'b0;
          coin_en_q   <= 1'b0;
          mess_en_q   <= 1'b1;
          msg_sel_q   <= MSG_TITLE;
          score_q     <= 8'd0;
          lives_q     <= 2'd0;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign char_en = char_en_q;
  assign coin_en = coin_en_q;
  assign mess_en = mess_en_q;
  assign msg_sel = msg_sel_q;
  assign score   = score_q;
  assign lives   = lives_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: a behavioural game model predicts the
// outputs for every cycle, the driver queues the prediction, and a monitor
// compares it with the DUT one step after each rising edge.
module tb_screen_sequencer;

  localparam int LIVES_INIT   = 3;
  localparam int WIN_SCORE    = 10;
  localparam int FLASH_FRAMES = 60;
  localparam int BLINK_FRAMES = 8;
  localparam int OVER_FRAMES  = 180;

  localparam int TITLE = 0, PLAY = 1, FLASH = 2, OVER = 3;

  typedef struct packed {
    logic [1:0] st;
    logic       ch;
    logic       co;
    logic       me;
    logic [1:0] msg;
    logic [7:0] sc;
    logic [1:0] lv;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b1;
  logic       coin_hit = 1'b0;
  logic       char_hit = 1'b0;
  logic [1:0] state;
  logic       char_en, coin_en, mess_en;
  logic [1:0] msg_sel;
  logic [7:0] score;
  logic [1:0] lives;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  outs_t sb_q[$];

  screen_sequencer #(
    .LIVES_INIT(LIVES_INIT), .WIN_SCORE(WIN_SCORE), .FLASH_FRAMES(FLASH_FRAMES),
    .BLINK_FRAMES(BLINK_FRAMES), .OVER_FRAMES(OVER_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
    .coin_hit(coin_hit), .char_hit(char_hit), .state(state), .char_en(char_en),
    .coin_en(coin_en), .mess_en(mess_en), .msg_sel(msg_sel), .score(score),
    .lives(lives)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_state = TITLE;
  int m_score = 0;
  int m_lives = 0;
  int m_msg   = 0;
  int m_ticks = 0;   // frame ticks counted since entering the current screen
  bit m_btn_prev = 1'b1;

  task automatic go_to(input int s);
    m_state = s;
    m_ticks = 0;
  endtask

  task automatic model_step(input bit rst, input bit tick, input bit btn,
                            input bit coin, input bit hit);
    bit rise;
    if (!rst) begin
      m_state = TITLE; m_score = 0; m_lives = 0; m_msg = 0; m_ticks = 0;
      m_btn_prev = 1'b1;
      return;
    end
    rise = btn && !m_btn_prev;
    m_btn_prev = btn;
    case (m_state)
      TITLE: begin
        if (rise) begin
          go_to(PLAY); m_score = 0; m_lives = LIVES_INIT;
        end else if (tick) m_ticks++;
      end
      PLAY: begin
        if (coin) m_score = (m_score >= 255) ? 255 : m_score + 1;
        if (hit) m_lives = m_lives - 1;
        if (coin && m_score == WIN_SCORE) begin go_to(OVER); m_msg = 1; end
        else if (hit && m_lives == 0)     begin go_to(OVER); m_msg = 2; end
        else if (hit)                     go_to(FLASH);
      end
      FLASH: begin
        if (coin) m_score = (m_score >= 255) ? 255 : m_score + 1;
        if (coin && m_score == WIN_SCORE) begin go_to(OVER); m_msg = 1; end
        else if (tick) begin
          m_ticks++;
          if (m_ticks >= FLASH_FRAMES) go_to(PLAY);
        end
      end
      default: begin
        if (rise || (tick && m_ticks + 1 >= OVER_FRAMES)) begin
          go_to(TITLE); m_msg = 0;
        end else if (tick) m_ticks++;
      end
    endcase
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    o.st  = 2'(m_state);
    o.msg = 2'(m_msg);
    o.sc  = 8'(m_score);
    o.lv  = 2'(m_lives);
    case (m_state)
      TITLE: begin
        o.ch = 1'b0; o.co = 1'b0;
`ifdef SCREEN_SEQ_MSG_BLINK_EN
        o.me = ((m_ticks / BLINK_FRAMES) % 2) == 0;
`else
        o.me = 1'b1;
`endif
      end
      PLAY:  begin o.ch = 1'b1; o.co = 1'b1; o.me = 1'b0; end
      FLASH: begin o.ch = ((m_ticks / BLINK_FRAMES) % 2) == 1; o.co = 1'b1; o.me = 1'b0; end
      default: begin o.ch = 1'b0; o.co = 1'b0; o.me = 1'b1; end
    endcase
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input bit rst, input bit tick, input bit btn,
                     input bit coin, input bit hit);
    @(negedge clk);
    rst_n = rst; frame_tick = tick; start_btn = btn;
    coin_hit = coin; char_hit = hit;
    model_step(rst, tick, btn, coin, hit);
    sb_q.push_back(model_outs());
  endtask

  // n frame ticks, each followed by an idle cycle.
  task automatic frames(input int n, input bit btn);
    for (int i = 0; i < n; i++) begin
      cyc(1, 1, btn, 0, 0);
      cyc(1, 0, btn, 0, 0);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    outs_t got, exp_o;
    #1;
    cycle_no++;
    if (sb_q.size() > 0) begin
      exp_o = sb_q.pop_front();
      got = '{st: state, ch: char_en, co: coin_en, me: mess_en,
              msg: msg_sel, sc: score, lv: lives};
      checks++;
      if (got !== exp_o) begin
        failures++;
        $display("FAIL outputs cycle=%0d got st=%0d ch=%0b co=%0b me=%0b msg=%0d sc=%0d lv=%0d exp st=%0d ch=%0b co=%0b me=%0b msg=%0d sc=%0d lv=%0d",
                 cycle_no, got.st, got.ch, got.co, got.me, got.msg, got.sc, got.lv,
                 exp_o.st, exp_o.ch, exp_o.co, exp_o.me, exp_o.msg, exp_o.sc, exp_o.lv);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit btn;
    // Reset with the button held; releasing reset must not start a game.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 1, 1);
    frames(3, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);                   // start

    // Ten coins: win on the tenth.
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 1, 1, 0);
      cyc(1, 1, 1, 0, 0);
    end
    // OVER: release button, 5 frames, then press -> TITLE.
    frames(5, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);

    // TITLE message blink (or steady) over 20 frames, then start.
    frames(20, 0);
    cyc(1, 0, 1, 0, 0);

    // Three hits, each after its flash; the third ends the game.
    for (int h = 0; h < 3; h++) begin
      cyc(1, 0, 1, 0, 1);
      frames(10, 1);
      cyc(1, 0, 1, 0, 1);                 // ignored while flashing
      frames(FLASH_FRAMES - 10, 1);
      cyc(1, 0, 1, 0, 0);
    end
    frames(OVER_FRAMES + 2, 1);           // auto-return to TITLE

    // Score 9, lives 1, then coin and hit together: win has priority.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    for (int h = 0; h < 2; h++) begin
      cyc(1, 0, 1, 0, 1);
      frames(FLASH_FRAMES, 1);
    end
    for (int i = 0; i < 9; i++) cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 1);
    frames(3, 1);

    // Coin win while flashing, with a frame tick on the same cycle.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);                   // OVER -> TITLE
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);                   // TITLE -> PLAY
    for (int i = 0; i < 9; i++) cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 1);
    frames(4, 1);
    cyc(1, 1, 1, 1, 0);
    frames(2, 1);

    // Randomised play with occasional mid-game resets.
    btn = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 24) == 0) btn = ~btn;
      cyc(($urandom_range(0, 799) != 0),
          ($urandom_range(0, 2) == 0),
          btn,
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 9) == 0));
    end

    cyc(1, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending entries, need 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Game-screen controller that sequences the VGA layer compositor: decides per frame whether the character, coin and message layers are enabled, and which message is shown.
- Tracks score and lives, and walks TITLE -> PLAY -> (FLASH) -> OVER.
- Outputs gate the per-layer RGB bits before they enter the layer-priority mixer.
- Advances time only on frame_tick, one pulse per frame derived from vsync.

Parameters:
- LIVES_INIT, 3, lives loaded on game start (1..3).
- WIN_SCORE, 10, score that ends the game as a win (1..255).
- FLASH_FRAMES, 60, length of the post-hit invulnerable flash, in frames (1..255).
- BLINK_FRAMES, 8, half-period of the character blink during FLASH, in frames (1..255).
- OVER_FRAMES, 180, frames the OVER screen is held before auto-return to TITLE (1..255).

Ports:
- clk  in  1  pixel/system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame.
- start_btn  in  1  already-synchronized, debounced level.
- coin_hit  in  1  one-cycle pulse: character touched the coin.
- char_hit  in  1  one-cycle pulse: character touched a hazard.
- state  out  2  0=TITLE, 1=PLAY, 2=FLASH, 3=OVER.
- char_en  out  1  enable character layer.
- coin_en  out  1  enable coin layer.
- mess_en  out  1  enable message layer.
- msg_sel  out  2  0=title text, 1=win text, 2=lose text, 3=unused.
- score  out  8  coins collected this game.
- lives  out  2  remaining lives.

Behaviour:
- All outputs registered; output changes take effect on the clock edge after the causing input is sampled (1-cycle latency).
- Reset (rst_n=0 at a clk edge):
  - state=TITLE, char_en=0, coin_en=0, mess_en=1, msg_sel=0, score=0, lives=0.
  - Frame counter and blink toggle cleared.
  - start_q set to 1, so a button held through reset does not start a game.
  - Reset mid-game aborts immediately to these values.
- Start edge: start_rise = start_btn & ~start_q; start_q <= start_btn every cycle.
- TITLE:
  - Outputs: mess_en=1, msg_sel=0, char_en=0, coin_en=0.
  - start_rise -> PLAY; score<=0; lives<=LIVES_INIT.
  - coin_hit and char_hit are ignored.
- PLAY:
  - Outputs: char_en=1, coin_en=1, mess_en=0.
  - coin_hit: score<=score+1. If the new score == WIN_SCORE -> OVER with msg_sel=1.
  - char_hit: lives<=lives-1. If the new lives == 0 -> OVER with msg_sel=2; else -> FLASH.
  - coin_hit and char_hit in the same cycle: both counters update. Win check has priority over the lose check, which has priority over FLASH.
  - Score saturates at 255; it never wraps.
- FLASH:
  - Outputs: coin_en=1, mess_en=0.
  - char_en starts at 0 on entry and toggles every BLINK_FRAMES frame_ticks.
  - After FLASH_FRAMES frame_ticks -> PLAY with char_en=1.
  - char_hit is ignored (invulnerable); coin_hit still scores and can trigger a win.
- OVER:
  - Outputs: mess_en=1, char_en=0, coin_en=0; msg_sel is held at its value from entry.
  - After OVER_FRAMES frame_ticks, or on start_rise, whichever comes first -> TITLE with msg_sel=0.
  - score and lives hold until the next start.
- Frame counter (8 bit):
  - Cleared on every state entry.
  - A frame_tick in the same cycle as a state transition is not counted.
  - Counts only in FLASH and OVER.
  - Compares with ==; no wrap is reachable.
- Illegal state encodings are not reachable; the default branch returns to TITLE with reset output values.

Optional Feature:
- Macro: SCREEN_SEQ_MSG_BLINK_EN.
- Defined: in TITLE, mess_en toggles every BLINK_FRAMES frame_ticks, starting at 1 on TITLE entry. The toggle uses the shared frame counter. OVER stays steady.
- Undefined: mess_en is steady 1 in TITLE. No extra logic is generated.

Test Plan:
- Reset held 2 cycles with start_btn=1, then released -> state=0, mess_en=1, msg_sel=0, lives=0. No start occurs until start_btn falls and rises again.
- Start, then 10 coin_hit pulses -> score counts 1..10. On the 10th pulse, the next cycle shows state=3, msg_sel=1, char_en=0, coin_en=0, mess_en=1.
- Start, then char_hit -> lives=2, state=2, char_en=0.
  - After 8 frame_ticks, char_en=1.
  - After 60 frame_ticks, state=1 and char_en=1.
  - A char_hit sent during FLASH leaves lives at 2.
- Three char_hit pulses, each after its flash completes -> after the third, lives=0, state=3, msg_sel=2. After 180 frame_ticks, state=0 and msg_sel=0.
- With score=9 and lives=1, coin_hit and char_hit in the same cycle -> score=10, lives=0, state=3, msg_sel=1 (win priority).
- In OVER, start_rise after 5 frame_ticks -> TITLE next cycle. With SCREEN_SEQ_MSG_BLINK_EN defined, mess_en in TITLE reads 1,0,1 across 0/8/16 frame_ticks; undefined, it stays 1.
